// File: rtl/jtag_dtm_regs.sv
// -----------------------------------------------------------------------------
// jtag_dtm_regs
// Instruction register and data-register bank of the JTAG debug transport
// module. Sits directly behind the TAP state machine: consumes its capture /
// shift / update strobes, shifts TDI through the selected register, drives
// TDO, and turns DMI scans into a valid/ready request toward the debug module
// while collecting the response for the next scan.
//
// Ports
//   tck_i, rst_i                      JTAG clock (state on posedge, TDO on
//                                     negedge), async active-high reset
//   tdi_i                             serial data in
//   captureIR_i/shiftIR_i/updateIR_i  TAP IR strobes (one tck each)
//   captureDR_i/shiftDR_i/updateDR_i  TAP DR strobes
//   selectIR_i                        1 = TDO sourced from the IR chain
//   tdo_o, tdo_en_o                   serial data out and its drive enable
//   dmi_req_*                         DMI request (valid/ready, addr, data, op)
//   dmi_resp_*                        DMI response strobe, data, error
//   dmi_hardreset_o                   one-tck pulse on dtmcs.dmihardreset
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module jtag_dtm_regs #(
    parameter int unsigned IR_W       = 5,
    parameter int unsigned ABITS      = 7,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter logic [2:0]  IDLE_HINT  = 3'd1
) (
    input  logic             tck_i,
    input  logic             rst_i,
    input  logic             tdi_i,
    input  logic             captureIR_i,
    input  logic             shiftIR_i,
    input  logic             updateIR_i,
    input  logic             captureDR_i,
    input  logic             shiftDR_i,
    input  logic             updateDR_i,
    input  logic             selectIR_i,
    output logic             tdo_o,
    output logic             tdo_en_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [31:0]      dmi_req_data_o,
    output logic [1:0]       dmi_req_op_o,
    input  logic             dmi_resp_valid_i,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic             dmi_resp_err_i,
    output logic             dmi_hardreset_o
);

    localparam int unsigned   DMI_W       = ABITS + 34;
    localparam logic [5:0]    ABITS_FIELD = 6'(ABITS);

    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(5'h01);
    localparam logic [IR_W-1:0] IR_DTMCS  = IR_W'(5'h10);
    localparam logic [IR_W-1:0] IR_DMI    = IR_W'(5'h11);

    // Which data register sits between TDI and TDO; unknown opcodes fall
    // through to BYPASS.
    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_DTMCS,
        SEL_DMI
    } dr_sel_e;

    // IR path
    logic [IR_W-1:0]  r_ir;
    logic [IR_W-1:0]  r_ir_sr;

    // DR shift registers
    logic [31:0]      r_idcode_sr;
    logic             r_bypass_sr;
    logic [31:0]      r_dtmcs_sr;
    logic [DMI_W-1:0] r_dmi_sr;

    // DMI bookkeeping
    logic             r_req_valid;
    logic [ABITS-1:0] r_req_addr;
    logic [31:0]      r_req_data;
    logic [1:0]       r_req_op;
    logic [ABITS-1:0] r_last_addr;
    logic [31:0]      r_resp_data;
    logic             r_outstanding;
    logic             r_sticky_busy;
    logic             r_sticky_err;
    logic             r_hardreset;

    dr_sel_e          w_dr_sel;
    logic             w_dr_tdo;
    logic [1:0]       w_status;
    logic [1:0]       w_dmi_status;
    logic [ABITS-1:0] w_upd_addr;
    logic [31:0]      w_upd_data;
    logic [1:0]       w_upd_op;
    logic             w_upd_is_req;

    // -------------------------------------------------------------------------
    // Decode and status
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_dr_sel = SEL_BYPASS;
        case (r_ir)
            IR_IDCODE: w_dr_sel = SEL_IDCODE;
            IR_DTMCS:  w_dr_sel = SEL_DTMCS;
            IR_DMI:    w_dr_sel = SEL_DMI;
            default:   w_dr_sel = SEL_BYPASS;
        endcase
    end

    always_comb begin
        w_dr_tdo = r_bypass_sr;
        case (w_dr_sel)
            SEL_IDCODE: w_dr_tdo = r_idcode_sr[0];
            SEL_DTMCS:  w_dr_tdo = r_dtmcs_sr[0];
            SEL_DMI:    w_dr_tdo = r_dmi_sr[0];
            default:    w_dr_tdo = r_bypass_sr;
        endcase
    end

    // Busy dominates error in the two-bit status code.
    assign w_status     = r_sticky_busy ? 2'd3 : (r_sticky_err ? 2'd2 : 2'd0);
    // A capture while a request is still in flight reports busy right away.
    assign w_dmi_status = r_outstanding ? 2'd3 : w_status;

    assign w_upd_addr   = r_dmi_sr[DMI_W-1:34];
    assign w_upd_data   = r_dmi_sr[33:2];
    assign w_upd_op     = r_dmi_sr[1:0];
    assign w_upd_is_req = (w_upd_op == 2'd1) || (w_upd_op == 2'd2);

    // -------------------------------------------------------------------------
    // IR path
    // -------------------------------------------------------------------------
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            r_ir    <= IR_IDCODE;
            r_ir_sr <= '0;
        end else begin
            if (captureIR_i) begin
                r_ir_sr <= IR_W'(5'b00001);
            end else if (shiftIR_i) begin
                r_ir_sr <= {tdi_i, r_ir_sr[IR_W-1:1]};
            end
            if (updateIR_i) begin
                r_ir <= r_ir_sr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // DR shift registers: only the one selected by IR captures or shifts
    // -------------------------------------------------------------------------
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            r_idcode_sr <= '0;
            r_bypass_sr <= 1'b0;
            r_dtmcs_sr  <= '0;
            r_dmi_sr    <= '0;
        end else if (captureDR_i) begin
            case (w_dr_sel)
                SEL_IDCODE: r_idcode_sr <= IDCODE_VAL;
                SEL_DTMCS:  r_dtmcs_sr  <= {14'b0, 2'b00, 1'b0, IDLE_HINT,
                                            w_status, ABITS_FIELD, 4'd1};
                SEL_DMI:    r_dmi_sr    <= {r_last_addr, r_resp_data, w_dmi_status};
                default:    r_bypass_sr <= 1'b0;
            endcase
        end else if (shiftDR_i) begin
            case (w_dr_sel)
                SEL_IDCODE: r_idcode_sr <= {tdi_i, r_idcode_sr[31:1]};
                SEL_DTMCS:  r_dtmcs_sr  <= {tdi_i, r_dtmcs_sr[31:1]};
                SEL_DMI:    r_dmi_sr    <= {tdi_i, r_dmi_sr[DMI_W-1:1]};
                default:    r_bypass_sr <= tdi_i;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // DMI request / response and sticky status. Later statements win, so a
    // hard reset overrides a response or handshake landing on the same edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_req_data    <= '0;
            r_req_op      <= '0;
            r_last_addr   <= '0;
            r_resp_data   <= '0;
            r_outstanding <= 1'b0;
            r_sticky_busy <= 1'b0;
            r_sticky_err  <= 1'b0;
            r_hardreset   <= 1'b0;
        end else begin
            r_hardreset <= 1'b0;

            if (r_req_valid && dmi_req_ready_i) begin
                r_req_valid <= 1'b0;
            end

            if (dmi_resp_valid_i) begin
                r_resp_data   <= dmi_resp_data_i;
                r_outstanding <= 1'b0;
                if (dmi_resp_err_i) begin
                    r_sticky_err <= 1'b1;
                end
            end

            if (captureDR_i && (w_dr_sel == SEL_DMI) && r_outstanding) begin
                r_sticky_busy <= 1'b1;
            end

            if (updateDR_i && (w_dr_sel == SEL_DTMCS)) begin
                if (r_dtmcs_sr[16]) begin
                    r_sticky_busy <= 1'b0;
                    r_sticky_err  <= 1'b0;
                end
                if (r_dtmcs_sr[17]) begin
                    r_hardreset   <= 1'b1;
                    r_sticky_busy <= 1'b0;
                    r_sticky_err  <= 1'b0;
                    r_outstanding <= 1'b0;
                    r_req_valid   <= 1'b0;
                end
            end

            if (updateDR_i && (w_dr_sel == SEL_DMI) && w_upd_is_req) begin
                if (r_outstanding) begin
                    r_sticky_busy <= 1'b1;
                end else if (!r_sticky_busy && !r_sticky_err) begin
                    r_req_valid   <= 1'b1;
                    r_req_addr    <= w_upd_addr;
                    r_req_data    <= w_upd_data;
                    r_req_op      <= w_upd_op;
                    r_outstanding <= 1'b1;
                    r_last_addr   <= w_upd_addr;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // TDO launches on the falling edge so the probe samples it on the next
    // rising edge with a full half period of setup.
    // -------------------------------------------------------------------------
    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_o    <= 1'b0;
            tdo_en_o <= 1'b0;
        end else begin
            tdo_o    <= selectIR_i ? r_ir_sr[0] : w_dr_tdo;
            tdo_en_o <= shiftIR_i | shiftDR_i;
        end
    end

    assign dmi_req_valid_o = r_req_valid;
    assign dmi_req_addr_o  = r_req_addr;
    assign dmi_req_data_o  = r_req_data;
    assign dmi_req_op_o    = r_req_op;
    assign dmi_hardreset_o = r_hardreset;

endmodule
